// File: rtl/ifm_s2mm_arb.sv
// rtl/ifm_s2mm_arb.sv - frame-granular round-robin arbiter draining FWFT frame FIFOs into one S2MM stream
module ifm_s2mm_arb #(
    parameter int C_NUM_PORTS = 4,
    parameter int C_PORT_W    = 2,
    parameter int C_CNT_W     = 16
) (
    input  logic                       s2mm_clk,
    input  logic                       rx_reset,
    input  logic [73*C_NUM_PORTS-1:0]  fifo_rdata,
    input  logic [C_NUM_PORTS-1:0]     fifo_empty,
    output logic [C_NUM_PORTS-1:0]     fifo_rden,
    output logic [63:0]                m_tdata,
    output logic [7:0]                 m_tkeep,
    output logic                       m_tlast,
    output logic [C_PORT_W-1:0]        m_tdest,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [C_CNT_W-1:0]         frm_cnt,
    output logic                       busy
);

    typedef enum logic {
        S_ARB,
        S_XFER
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [C_PORT_W-1:0] gnt;
    logic [C_PORT_W-1:0] gnt_nxt;
    logic [C_PORT_W-1:0] ptr;
    logic [C_PORT_W-1:0] ptr_nxt;
    logic                load;
    logic                pop;
    logic [72:0]         head;
    logic                found;
    logic [C_PORT_W-1:0] pick;

    assign load = !m_tvalid || m_tready;
    assign busy = (state == S_XFER);

    always_comb begin
        head = '0;
        for (int p = 0; p < C_NUM_PORTS; p++) begin
            if (gnt == C_PORT_W'(p)) begin
                head = fifo_rdata[73*p +: 73];
            end
        end
    end

    // Walk the rotation from the lowest priority upward so the last hit is the highest-priority port.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = C_NUM_PORTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % C_NUM_PORTS;
            for (int p = 0; p < C_NUM_PORTS; p++) begin
                if (p == idx && !fifo_empty[p]) begin
                    found = 1'b1;
                    pick  = C_PORT_W'(p);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        fifo_rden = '0;
        pop       = 1'b0;
        case (state)
            S_ARB: begin
                if (found) begin
                    gnt_nxt   = pick;
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                for (int p = 0; p < C_NUM_PORTS; p++) begin
                    if (gnt == C_PORT_W'(p) && !fifo_empty[p] && load && !rx_reset) begin
                        fifo_rden[p] = 1'b1;
                    end
                end
                pop = |fifo_rden;
                if (pop && head[72]) begin
                    ptr_nxt   = (gnt == C_PORT_W'(C_NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
                    state_nxt = S_ARB;
                end
            end
            default: begin
                state_nxt = S_ARB;
            end
        endcase
    end

    always_ff @(posedge s2mm_clk) begin
        if (rx_reset) begin
            state <= S_ARB;
            gnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Output register keeps its payload when it empties so a stalled beat stays stable.
    always_ff @(posedge s2mm_clk) begin
        if (rx_reset) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tdest  <= '0;
            frm_cnt  <= '0;
        end else begin
            if (m_tvalid && m_tready && m_tlast) begin
                frm_cnt <= frm_cnt + 1'b1;
            end
            if (load) begin
                if (pop) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= head[63:0];
                    m_tkeep  <= head[71:64];
                    m_tlast  <= head[72];
                    m_tdest  <= gnt;
                end else begin
                    m_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifm_s2mm_arb.sv
// tb/tb_ifm_s2mm_arb.sv - self-checking bench for ifm_s2mm_arb with FIFO and scoreboard models
module tb_ifm_s2mm_arb;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [73*N-1:0]   rdata = '0;
    logic [N-1:0]      empty = '1;
    logic [N-1:0]      rden;
    logic [63:0]       tdata;
    logic [7:0]        tkeep;
    logic              tlast;
    logic [PW-1:0]     tdest;
    logic              tvalid;
    logic              tready = 1'b1;
    logic [CW-1:0]     frm_cnt;
    logic              busy;

    always #5 clk = ~clk;

    ifm_s2mm_arb #(.C_NUM_PORTS(N), .C_PORT_W(PW), .C_CNT_W(CW)) dut (
        .s2mm_clk(clk), .rx_reset(rst), .fifo_rdata(rdata), .fifo_empty(empty),
        .fifo_rden(rden), .m_tdata(tdata), .m_tkeep(tkeep), .m_tlast(tlast),
        .m_tdest(tdest), .m_tvalid(tvalid), .m_tready(tready), .frm_cnt(frm_cnt), .busy(busy)
    );

    typedef struct {
        int         last;
        logic [3:0] mask;
        int         exp_port;
    } arb_vec_t;

    logic [72:0] q     [N][$];
    logic [72:0] exp_q [N][$];
    int          ord_q [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          mcnt = 0;
    int          mptr = 0;
    int          cur_src = 0;
    bit          in_frame = 0;
    bit          stall_prev = 0;
    bit          rst_prev = 1;
    logic [75:0] hold_val = '0;
    logic [N-1:0] s_rden;
    logic        s_tvalid, s_tlast;
    logic [PW-1:0] s_tdest;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int p, input logic eof);
        logic [72:0] w;
        w = {eof, 8'($urandom), $urandom, $urandom};
        q[p].push_back(w);
        exp_q[p].push_back(w);
    endtask

    task automatic clear_model();
        for (int p = 0; p < N; p++) begin
            q[p].delete();
            exp_q[p].delete();
        end
        ord_q.delete();
        in_frame   = 0;
        stall_prev = 0;
    endtask

    function automatic bit pending();
        bit r;
        r = tvalid;
        for (int p = 0; p < N; p++) if (exp_q[p].size() != 0) r = 1;
        return r;
    endfunction

    // Called at the negedge; returns at the following negedge.
    task automatic step();
        logic [N-1:0] rs;
        int d, e;
        logic [72:0] w;
        case (rdy_mode)
            1: tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2: tready = ($urandom_range(0, 9) < 7);
            default: tready = 1'b1;
        endcase
        for (int p = 0; p < N; p++) begin
            empty[p] = (q[p].size() == 0);
            rdata[73*p +: 73] = empty[p] ? 73'd0 : q[p][0];
        end
        #1;
        rs = rden;
        s_rden = rs; s_tvalid = tvalid; s_tlast = tlast; s_tdest = tdest;
        if (!rst) begin
            chk("rden_legal", 80'(((rs & empty) == 0) && $onehot0(rs) && (rs == 0 || !tvalid || tready)), 80'(1));
            if (stall_prev && !rst_prev)
                chk("stall_hold", 80'({tvalid, tlast, tkeep, tdata, tdest}), 80'(hold_val));
            chk("frm_cnt", 80'(frm_cnt), 80'(mcnt % 16));
            if (tvalid && tready) begin
                d = int'(tdest);
                if (in_frame) chk("no_interleave", 80'(d), 80'(cur_src));
                else if (ord_q.size() > 0) begin
                    e = ord_q.pop_front();
                    chk("frame_src", 80'(d), 80'(e));
                end
                if (exp_q[d].size() == 0) chk("beat_expected", 80'(0), 80'(1));
                else begin
                    w = exp_q[d].pop_front();
                    chk("beat_word", 80'({tlast, tkeep, tdata}), 80'(w));
                end
                in_frame = !tlast;
                cur_src  = d;
                if (tlast) mcnt++;
            end
        end
        stall_prev = tvalid && !tready;
        hold_val   = {tvalid, tlast, tkeep, tdata, tdest};
        rst_prev   = rst;
        @(posedge clk);
        for (int p = 0; p < N; p++) if (rs[p]) void'(q[p].pop_front());
        if (rst) begin
            mcnt = 0;
            in_frame = 0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        for (int p = 0; p < N; p++) q[p].push_back(73'h1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rden", 80'(s_rden), 80'(0));
            chk("rst_tvalid", 80'(tvalid), 80'(0));
            chk("rst_frm_cnt", 80'(frm_cnt), 80'(0));
        end
        rst = 1'b0;
        clear_model();
        mptr = 0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (pending() && k < budget) begin
            step();
            k++;
        end
        chk("drain_in_budget", 80'(k < budget), 80'(1));
        chk("order_consumed", 80'(ord_q.size()), 80'(0));
    endtask

    arb_vec_t vecs [8];

    initial begin
        int first_v, last_v, nv, r0, cnt_r, first_r, last_r;
        int cnt [N];
        int total, len;

        vecs[0] = '{-1, 4'b1111, 0};
        vecs[1] = '{ 0, 4'b1111, 1};
        vecs[2] = '{ 1, 4'b1001, 3};
        vecs[3] = '{ 3, 4'b0110, 1};
        vecs[4] = '{ 2, 4'b0011, 0};
        vecs[5] = '{-1, 4'b1000, 3};
        vecs[6] = '{ 2, 4'b1100, 3};
        vecs[7] = '{ 3, 4'b1000, 3};

        @(negedge clk);
        do_reset();

        // Single port latency and throughput
        for (int w = 0; w < 4; w++) push(2, w == 3);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_rden2", 80'(s_rden[2]), 80'(k >= 1 && k <= 4));
            chk("t2_tvalid", 80'(s_tvalid), 80'(k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                chk("t2_tlast", 80'(s_tlast), 80'(k == 5));
                chk("t2_tdest", 80'(s_tdest), 80'(2));
            end
        end
        chk("t2_frm_cnt", 80'(frm_cnt), 80'(1));

        // Arbitration priority table
        foreach (vecs[i]) begin
            do_reset();
            if (vecs[i].last >= 0) begin
                push(vecs[i].last, 1'b1);
                drain(20);
            end
            for (int p = 0; p < N; p++) if (vecs[i].mask[p]) push(p, 1'b1);
            ord_q.push_back(vecs[i].exp_port);
            drain(40);
        end

        // Fairness across three ports with one bubble between frames
        do_reset();
        for (int f = 0; f < 2; f++)
            foreach (cnt[p]) if (p != 2) for (int w = 0; w < 3; w++) push(p, w == 2);
        for (int f = 0; f < 2; f++) begin
            ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(3);
        end
        first_v = -1; last_v = -1; nv = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (s_tvalid) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                nv++;
            end
        end
        chk("t3_span", 80'(last_v - first_v + 1), 80'(23));
        chk("t3_beats", 80'(nv), 80'(18));
        chk("t3_frm_cnt", 80'(frm_cnt), 80'(6));
        chk("t3_order_done", 80'(ord_q.size()), 80'(0));

        // Backpressure 1,0,0,1
        do_reset();
        rdy_mode = 1;
        for (int f = 0; f < 2; f++) for (int w = 0; w < 5; w++) push(0, w == 4);
        push(1, 1'b1);
        for (int w = 0; w < 4; w++) push(3, w == 3);
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(3); ord_q.push_back(0);
        drain(300);
        rdy_mode = 0;

        // Underflow mid-frame keeps the grant
        do_reset();
        push(0, 1'b1);
        ord_q.push_back(0);
        drain(20);
        push(1, 1'b0); push(1, 1'b0);
        push(0, 1'b0); push(0, 1'b1);
        ord_q.push_back(1); ord_q.push_back(0);
        r0 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (s_rden[0]) r0++;
        end
        chk("t5_port0_untouched", 80'(r0), 80'(0));
        chk("t5_port0_depth", 80'(q[0].size()), 80'(2));
        chk("t5_busy", 80'(busy), 80'(1));
        chk("t5_port1_beats_out", 80'(exp_q[1].size()), 80'(0));
        push(1, 1'b0); push(1, 1'b0); push(1, 1'b1);
        drain(60);

        // Single-word frames and counter wrap
        do_reset();
        for (int f = 0; f < 17; f++) push(1, 1'b1);
        cnt_r = 0; first_r = -1; last_r = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (s_rden != 0) begin
                if (first_r < 0) first_r = k;
                last_r = k;
                cnt_r++;
            end
        end
        chk("t6_pops", 80'(cnt_r), 80'(17));
        chk("t6_pop_span", 80'(last_r - first_r), 80'(32));
        chk("t6_frm_cnt_wrap", 80'(frm_cnt), 80'(1));

        // Reset in the middle of a 5-word frame
        for (int w = 0; w < 5; w++) push(2, w == 4);
        for (int k = 0; k < 20 && exp_q[2].size() > 3; k++) step();
        chk("t6_mid_frame", 80'(exp_q[2].size()), 80'(3));
        rst = 1'b1;
        step();
        chk("t6_rst_tvalid", 80'(tvalid), 80'(0));
        chk("t6_rst_state", 80'(busy), 80'(0));
        rst = 1'b0;
        clear_model();
        mptr = 0;
        step();
        chk("t6_post_rst_rden", 80'(s_rden), 80'(0));

        // Randomized frames against a frame-order model
        do_reset();
        rdy_mode = 2;
        for (int it = 0; it < 8; it++) begin
            total = 0;
            for (int p = 0; p < N; p++) begin
                cnt[p] = $urandom_range(0, 3);
                total += cnt[p];
                for (int f = 0; f < cnt[p]; f++) begin
                    len = $urandom_range(1, 5);
                    for (int w = 0; w < len; w++) push(p, w == len - 1);
                end
            end
            for (int t = 0; t < total; t++) begin
                for (int i = 0; i < N; i++) begin
                    int p;
                    p = (mptr + i) % N;
                    if (cnt[p] > 0) begin
                        ord_q.push_back(p);
                        cnt[p]--;
                        mptr = (p + 1) % N;
                        break;
                    end
                end
            end
            drain(2000);
        end
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
